// File: rtl/conv_feeder.sv
// conv_feeder: source-side driver for the streaming convolution engine.
// On a start pulse it reads KSIZE*KSIZE weights from word memory into the
// engine's weight register file, then streams the image one pixel per cycle.
// Optional build macro: CONV_FEED_PAD_EN adds a zero-pad border of
// (KSIZE-1)/2 pixels around the streamed image.
module conv_feeder #(
   parameter int IMG_W = 32,
   parameter int IMG_H = 32,
   parameter int KSIZE = 5,
   parameter int AW    = 16,
   parameter int WBASE = 0,
   parameter int XBASE = 32
) (
   input  logic          iCLK,
   input  logic          iRSTn,
   input  logic          iStart,
   output logic          oBusy,
   output logic          oDone,
   output logic          oMemRen,
   output logic [AW-1:0] oMemAddr,
   input  logic [31:0]   iMemData,
   output logic [31:0]   oW,
   output logic [9:0]    oADDR,
   output logic          oWren,
   output logic [31:0]   oX,
   output logic          oValid
);

   localparam int NW = KSIZE * KSIZE;
`ifdef CONV_FEED_PAD_EN
   localparam int P  = (KSIZE - 1) / 2;
`else
   localparam int P  = 0;
`endif
   // streamed frame size, including any pad border
   localparam int SW = IMG_W + 2 * P;
   localparam int SH = IMG_H + 2 * P;
   localparam int CW = $clog2(SW + 1);
   localparam int RW = $clog2(SH + 1);

   localparam logic [9:0]    K_LAST = 10'(NW - 1);
   localparam logic [CW-1:0] C_LAST = CW'(SW - 1);
   localparam logic [RW-1:0] R_LAST = RW'(SH - 1);
   localparam logic [AW-1:0] WB     = AW'(WBASE);
   localparam logic [AW-1:0] XB     = AW'(XBASE);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOADW  = 2'd1;
   localparam logic [1:0] S_STREAM = 2'd2;
   localparam logic [1:0] S_DRAIN  = 2'd3;

   logic [1:0]    state;
   logic [9:0]    k;
   logic [CW-1:0] c;
   logic [RW-1:0] r;
   logic [AW-1:0] xptr;      // running pixel address; avoids an r*IMG_W multiply
   logic          tag_w;     // read issued last cycle was a weight
   logic          tag_px;    // read (or pad slot) issued last cycle was a pixel
   logic [9:0]    addr_q;
   logic [31:0]   w_hold;
   logic [31:0]   x_hold;
   logic          done_q;
   logic          border;
   logic [31:0]   px;

`ifdef CONV_FEED_PAD_EN
   localparam logic [CW-1:0] C_LO = CW'(P);
   localparam logic [CW-1:0] C_HI = CW'(P + IMG_W);
   localparam logic [RW-1:0] R_LO = RW'(P);
   localparam logic [RW-1:0] R_HI = RW'(P + IMG_H);
   logic tag_zero;

   // border positions skip the memory read and present a zero pixel
   assign border = (c < C_LO) || (c >= C_HI) || (r < R_LO) || (r >= R_HI);
   assign px     = tag_zero ? 32'd0 : iMemData;

   // zero flag travels alongside the pixel tag
   always_ff @(posedge iCLK or negedge iRSTn)
      if (!iRSTn) tag_zero <= 1'b0;
      else        tag_zero <= (state == S_STREAM) && border;
`else
   assign border = 1'b0;
   assign px     = iMemData;
`endif

   // read request is a direct decode of state and counters
   always_comb begin
      oMemRen  = 1'b0;
      oMemAddr = '0;
      if (state == S_LOADW) begin
         oMemRen  = 1'b1;
         oMemAddr = WB + AW'(k);
      end else if (state == S_STREAM) begin
         oMemRen  = !border;
         oMemAddr = xptr;
      end
   end

   // control FSM and position counters
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         state <= S_IDLE;
         k     <= '0;
         c     <= '0;
         r     <= '0;
         xptr  <= '0;
      end else begin
         case (state)
            S_IDLE:
               // done_q blocks a start in the cycle that reports completion
               if (iStart && !done_q) begin
                  state <= S_LOADW;
                  k     <= '0;
                  c     <= '0;
                  r     <= '0;
                  xptr  <= XB;
               end
            S_LOADW: begin
               k <= k + 10'd1;
               if (k == K_LAST) state <= S_STREAM;
            end
            S_STREAM: begin
               if (!border) xptr <= xptr + AW'(1);
               if (c == C_LAST) begin
                  c <= '0;
                  r <= r + RW'(1);
                  if (r == R_LAST) state <= S_DRAIN;
               end else begin
                  c <= c + CW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // return-path tags, weight index and completion pulse
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         tag_w  <= 1'b0;
         tag_px <= 1'b0;
         addr_q <= '0;
         done_q <= 1'b0;
      end else begin
         tag_w  <= (state == S_LOADW);
         tag_px <= (state == S_STREAM);
         done_q <= (state == S_DRAIN);
         if (state == S_LOADW) addr_q <= k;
      end
   end

   // hold registers keep oW/oX stable while strobes are low
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         w_hold <= '0;
         x_hold <= '0;
      end else begin
         if (tag_w)  w_hold <= iMemData;
         if (tag_px) x_hold <= px;
      end
   end

   assign oWren  = tag_w;
   assign oValid = tag_px;
   assign oADDR  = addr_q;
   assign oW     = tag_w  ? iMemData : w_hold;
   assign oX     = tag_px ? px       : x_hold;
   assign oBusy  = (state != S_IDLE);
   assign oDone  = done_q;

endmodule

// File: tb/tb_conv_feeder.sv
// Directed bench for conv_feeder with a 4x3 image and 5x5 kernel.
module tb_conv_feeder;

   localparam int NW = 25;
`ifdef CONV_FEED_PAD_EN
   localparam int NPIX = 56;
`else
   localparam int NPIX = 12;
`endif
   localparam int J = NW + NPIX + 2;   // done cycle relative to start edge

   logic        iCLK = 1'b0;
   logic        iRSTn = 1'b0;
   logic        iStart = 1'b0;
   logic        oBusy, oDone, oMemRen, oWren, oValid;
   logic [15:0] oMemAddr;
   logic [31:0] iMemData, oW, oX;
   logic [9:0]  oADDR;

   logic [31:0] mem [0:255];
   logic [31:0] mem_q = '0;

   int errs = 0;
   int checks = 0;

   always #5 iCLK = ~iCLK;

   always @(posedge iCLK) if (oMemRen) mem_q <= mem[oMemAddr[7:0]];
   assign iMemData = mem_q;

   conv_feeder #(.IMG_W(4), .IMG_H(3), .KSIZE(5), .AW(16), .WBASE(0), .XBASE(32)) dut (
      .iCLK(iCLK), .iRSTn(iRSTn), .iStart(iStart), .oBusy(oBusy), .oDone(oDone),
      .oMemRen(oMemRen), .oMemAddr(oMemAddr), .iMemData(iMemData), .oW(oW),
      .oADDR(oADDR), .oWren(oWren), .oX(oX), .oValid(oValid)
   );

   task automatic kick();
      @(negedge iCLK);
      iStart = 1'b1;
      @(posedge iCLK);
      #1 iStart = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge iCLK);
      checks++;
      if ({oBusy, oDone, oMemRen, oMemAddr, oW, oADDR, oWren, oX, oValid} !== '0) begin
         errs++;
         $display("FAIL reset_hold outputs got busy=%b done=%b ren=%b addr=%h w=%h a=%h wren=%b x=%h v=%b",
                  oBusy, oDone, oMemRen, oMemAddr, oW, oADDR, oWren, oX, oValid);
      end
      iRSTn = 1'b1;
      for (int n = 0; n < 100; n++) begin
         @(negedge iCLK);
         checks++;
         if ({oBusy, oDone, oMemRen, oMemAddr, oW, oADDR, oWren, oX, oValid} !== '0) begin
            errs++;
            $display("FAIL reset_idle cycle %0d outputs nonzero, expected all 0", n);
         end
      end
   endtask

   task automatic test_weight_load();
      logic ew, eb;
      kick();
      for (int n = 1; n <= J + 1; n++) begin
         @(negedge iCLK);
         ew = (n >= 2 && n <= NW + 1);
         eb = (n <= J - 1);
         checks++;
         if (oWren !== ew) begin errs++; $display("FAIL wl_wren n=%0d got %b exp %b", n, oWren, ew); end
         checks++;
         if (oBusy !== eb) begin errs++; $display("FAIL wl_busy n=%0d got %b exp %b", n, oBusy, eb); end
         if (ew) begin
            checks++;
            if (oADDR !== 10'(n - 2) || oW !== 32'((n - 2) * 3 - 7)) begin
               errs++;
               $display("FAIL wl_data n=%0d got a=%0d w=%0d exp a=%0d w=%0d",
                        n, oADDR, $signed(oW), n - 2, (n - 2) * 3 - 7);
            end
         end
         if (n <= NW + 1) begin
            checks++;
            if (oValid !== 1'b0) begin errs++; $display("FAIL wl_novalid n=%0d got %b exp 0", n, oValid); end
         end
         if (n <= NW) begin
            checks++;
            if (oMemRen !== 1'b1 || oMemAddr !== 16'(n - 1)) begin
               errs++;
               $display("FAIL wl_read n=%0d got ren=%b addr=%0d exp 1 %0d", n, oMemRen, oMemAddr, n - 1);
            end
         end
      end
   endtask

`ifndef CONV_FEED_PAD_EN
   task automatic test_image_stream();
      logic ev;
      kick();
      for (int n = 1; n <= J + 1; n++) begin
         @(negedge iCLK);
         ev = (n >= NW + 2 && n <= NW + NPIX + 1);
         checks++;
         if (oValid !== ev) begin errs++; $display("FAIL is_valid n=%0d got %b exp %b", n, oValid, ev); end
         if (ev) begin
            checks++;
            if (oX !== 32'(-(n - NW - 1))) begin
               errs++; $display("FAIL is_x n=%0d got %0d exp %0d", n, $signed(oX), -(n - NW - 1));
            end
         end
         if (n >= NW + 1 && n <= NW + NPIX) begin
            checks++;
            if (oMemRen !== 1'b1 || oMemAddr !== 16'(32 + n - NW - 1)) begin
               errs++;
               $display("FAIL is_read n=%0d got ren=%b addr=%0d exp 1 %0d", n, oMemRen, oMemAddr, 32 + n - NW - 1);
            end
         end
         checks++;
         if (oDone !== (n == J)) begin errs++; $display("FAIL is_done n=%0d got %b exp %b", n, oDone, n == J); end
         if (n == J) begin
            checks++;
            if (oBusy !== 1'b0) begin errs++; $display("FAIL is_busy_at_done got %b exp 0", oBusy); end
         end
         if (n == J + 1) begin
            checks++;
            if (oX !== 32'(-12)) begin errs++; $display("FAIL is_xhold got %0d exp -12", $signed(oX)); end
         end
      end
   endtask
`else
   task automatic test_pad();
      int pos, rr, cc, ex, nren;
      logic ev;
      nren = 0;
      kick();
      for (int n = 1; n <= J + 1; n++) begin
         @(negedge iCLK);
         if (oMemRen) nren++;
         ev = (n >= NW + 2 && n <= NW + NPIX + 1);
         checks++;
         if (oValid !== ev) begin errs++; $display("FAIL pad_valid n=%0d got %b exp %b", n, oValid, ev); end
         if (ev) begin
            pos = n - NW - 2;
            rr  = pos / 8;
            cc  = pos % 8;
            ex  = (rr < 2 || rr >= 5 || cc < 2 || cc >= 6) ? 0 : -((rr - 2) * 4 + (cc - 2) + 1);
            checks++;
            if (oX !== 32'(ex)) begin errs++; $display("FAIL pad_x r=%0d c=%0d got %0d exp %0d", rr, cc, $signed(oX), ex); end
         end
         checks++;
         if (oDone !== (n == J)) begin errs++; $display("FAIL pad_done n=%0d got %b exp %b", n, oDone, n == J); end
      end
      checks++;
      if (nren !== NW + 12) begin errs++; $display("FAIL pad_reads got %0d exp %0d", nren - NW, 12); end
   endtask
`endif

   task automatic test_back_to_back();
      logic ed, ew, eb;
      int ka;
      @(negedge iCLK);
      iStart = 1'b1;
      @(posedge iCLK);
      for (int n = 1; n <= 2 * J + 3; n++) begin
         @(negedge iCLK);
         ed = (n == J) || (n == 2 * J + 1);
         ew = (n >= 2 && n <= NW + 1) || (n >= J + 3 && n <= J + NW + 2);
         eb = (n <= J - 1) || (n >= J + 2 && n <= 2 * J);
         ka = (n <= J) ? n - 2 : n - J - 3;
         checks++;
         if (oDone !== ed) begin errs++; $display("FAIL b2b_done n=%0d got %b exp %b", n, oDone, ed); end
         checks++;
         if (oBusy !== eb) begin errs++; $display("FAIL b2b_busy n=%0d got %b exp %b", n, oBusy, eb); end
         checks++;
         if (oWren !== ew) begin errs++; $display("FAIL b2b_wren n=%0d got %b exp %b", n, oWren, ew); end
         if (ew) begin
            checks++;
            if (oADDR !== 10'(ka) || oW !== 32'(ka * 3 - 7)) begin
               errs++; $display("FAIL b2b_wdata n=%0d got a=%0d w=%0d exp a=%0d", n, oADDR, $signed(oW), ka);
            end
         end
         if (n == 2 * J + 1) iStart = 1'b0;
      end
   endtask

   task automatic test_abort();
      int nv;
      kick();
      repeat (NW + 6) @(negedge iCLK);
      checks++;
      if (oValid !== 1'b1) begin errs++; $display("FAIL ab_pix5_valid got %b exp 1", oValid); end
`ifndef CONV_FEED_PAD_EN
      checks++;
      if (oX !== 32'(-5)) begin errs++; $display("FAIL ab_pix5_x got %0d exp -5", $signed(oX)); end
`endif
      #2 iRSTn = 1'b0;
      #1;
      checks++;
      if ({oBusy, oDone, oMemRen, oMemAddr, oW, oADDR, oWren, oX, oValid} !== '0) begin
         errs++; $display("FAIL ab_async outputs not cleared busy=%b ren=%b v=%b x=%h", oBusy, oMemRen, oValid, oX);
      end
      repeat (2) @(negedge iCLK);
      iRSTn = 1'b1;
      for (int n = 0; n < 40; n++) begin
         @(negedge iCLK);
         checks++;
         if ({oDone, oValid, oWren, oBusy} !== 4'b0) begin
            errs++; $display("FAIL ab_quiet n=%0d got done=%b v=%b wren=%b busy=%b exp 0", n, oDone, oValid, oWren, oBusy);
         end
      end
      nv = 0;
      kick();
      for (int n = 1; n <= J + 1; n++) begin
         @(negedge iCLK);
         if (oValid) nv++;
         checks++;
         if (oDone !== (n == J)) begin errs++; $display("FAIL ab_rerun_done n=%0d got %b exp %b", n, oDone, n == J); end
      end
      checks++;
      if (nv !== NPIX) begin errs++; $display("FAIL ab_rerun_count got %0d exp %0d", nv, NPIX); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_0000 + 32'(i);
      for (int k = 0; k < NW; k++) mem[k] = 32'(k * 3 - 7);
      for (int i = 0; i < 12; i++) mem[32 + i] = 32'(-(i + 1));
      test_reset();
      test_weight_load();
`ifndef CONV_FEED_PAD_EN
      test_image_stream();
`else
      test_pad();
`endif
      test_back_to_back();
      test_abort();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout errors=%0d checks=%0d", errs, checks);
      $fatal(1);
   end

endmodule
